uart_rx_os16: RTL and testbench
===============================

// Module: uart_rx_os16
// PURPOSE
//  UART receiver (8N1 default) driven by the 16x-oversample baud square wave from baudrate_gen.
//  Synchronises the asynchronous rx line and frames start, data and stop bits.
//  Samples each bit at mid-point and presents a byte with a 1-cycle valid strobe.
//  Sits between the board RX pin and the application byte consumer; one clk domain.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, sent LSB first
//  OVERSAMPLE  16  baud ticks per bit; must equal the baudrate_gen oversample ratio
//  SYNC_STAGES 2   flip-flop stages on rx (minimum 2)
// PORTS
//  clk        in   1          system clock, 100 MHz
//  rst_n      in   1          asynchronous active-low reset
//  baud       in   1          16x-rate square wave, synchronous to clk; each rising edge = 1 tick
//  rx         in   1          serial input, idle high, asynchronous
//  data_out   out  DATA_BITS  last received byte; held until the next frame completes
//  data_valid out  1          1-clk pulse: data_out updated and stop bit good
//  frame_err  out  1          1-clk pulse: stop bit sampled low
//  busy       out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset: data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE, sync FFs=1, baud_d=0, counters=0.
//  Ticks:
//   - tick = baud & ~baud_d, with baud_d registered.
//   - All FSM decisions happen on tick cycles only.
//   - tick_cnt is 4 bits and wraps at OVERSAMPLE-1 back to 0.
//  IDLE
//   - On tick with rx_s==0: go to START, tick_cnt=0.
//  START
//   - On each tick: tick_cnt++.
//   - At tick_cnt==OVERSAMPLE/2-1 (7), i.e. mid start bit:
//     - rx_s==0: go to DATA, tick_cnt=0, bit_cnt=0.
//     - rx_s==1: glitch; return to IDLE with no pulse.
//  DATA
//   - At tick_cnt==OVERSAMPLE-1 (15): shift rx_s into shreg MSB (right-shift, so LSB-first yields the correct order), bit_cnt++, tick_cnt=0.
//   - After DATA_BITS samples: go to STOP.
//  STOP
//   - At tick_cnt==15:
//     - rx_s==1: data_out<=shreg, data_valid=1 for one clk, go to IDLE.
//     - rx_s==0: data_out<=shreg, frame_err=1 for one clk, go to BREAK.
//  BREAK
//   - Wait for a tick with rx_s==1, then go to IDLE.
//   - A held-low line (break condition) therefore never re-triggers a frame.
//  Timing and latency
//   - Pulses are registered; they assert the clk after the stop-bit sampling tick.
//   - data_valid and frame_err are never high together.
//   - Latency from the rx stop-bit midpoint edge is SYNC_STAGES+1..2 clk plus up to one tick.
//  Boundary conditions
//   - Back-to-back frames: a start edge on the first tick in IDLE after STOP must be accepted.
//   - No gap beyond the stop-bit half is required.
//   - rx low at reset release: enters START on first tick; valid only if a full frame follows.
//   - No output buffering; the consumer must take data_out before the next frame completes (about 1 ms at 9600).
//   - baud stuck high or low: no ticks; FSM holds state indefinitely, with no timeout.
//   - rst_n asserted mid-frame: everything clears immediately; the partial byte is discarded.
// STRUCTURE
//  Package uart_pkg:
//   - state localparams IDLE/START/DATA/STOP/BREAK (3-bit).
//   - OVERSAMPLE, MID_TICK=OVERSAMPLE/2-1, LAST_TICK=OVERSAMPLE-1.
//   - Shared with the future uart_tx.
//  Sub-module sync_2ff (SYNC_STAGES-deep, reset-to-1 synchroniser) for rx.
//  The tick edge detector and FSM stay inline.
// TESTING  (baud from real baudrate_gen: 1 tick = 650 clk, 1 bit = 10400 clk)
//  1. Send 0x55, stop=1 -> one data_valid pulse, data_out=0x55, frame_err never high, busy low after.
//  2. Send 0xA3 then immediately 0x00 -> two valid pulses, data_out=0xA3 then 0x00, about 10 bit-times apart.
//  3. rx low 3 ticks (1950 clk) then high -> busy pulses, no valid/frame_err, state back to IDLE.
//  4. Send 0x3C with stop=0, hold rx low 2 bit-times, then send 0x81 -> one frame_err, data_out=0x3C, then valid with 0x81.
//  5. Pull rst_n low mid-bit 4 of 0xFF, release, send 0x12 -> outputs 0 during reset, then single valid 0x12.
//  6. rx held low across reset release for 12 bit-times, then high, then send 0x7E -> frame_err once, then valid 0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and oversample constants
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = OVERSAMPLE / 2 - 1;
  localparam int LAST_TICK  = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-stage synchroniser that resets to the line idle level
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // shift the asynchronous input through the chain; resets high so an idle line reads idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - oversampling UART receiver with mid-bit sampling and framing check
module uart_rx_os16 #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 baud_d;
  logic                 tick;
  uart_state_t          state, state_nxt;
  logic [CNT_W-1:0]     tick_cnt, tick_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_out_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;

  sync_2ff #(
    .STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // remember last baud level so a rising edge becomes a single-cycle tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_d <= 1'b0;
    end else begin
      baud_d <= baud;
    end
  end

  assign tick = baud & ~baud_d;
  assign busy = (state != IDLE);

  // frame state, counters, shift register and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      data_out   <= data_out_nxt;
      data_valid <= valid_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  // framing decisions, taken only on tick cycles; pulses default low so they last one clk
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    data_out_nxt = data_out;
    valid_nxt    = 1'b0;
    ferr_nxt     = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt    = START;
            tick_cnt_nxt = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_nxt = '0;
            if (!rx_s) begin
              state_nxt   = DATA;
              bit_cnt_nxt = '0;
            end else begin
              // start bit vanished before its midpoint: treat as noise
              state_nxt = IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_nxt = '0;
            // LSB arrives first, so shifting right leaves it at bit 0 after the last bit
            shreg_nxt    = {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt_nxt  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_nxt = '0;
            data_out_nxt = shreg;
            if (rx_s) begin
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        BREAK: begin
          // a line held low must go high before a new start bit can be seen
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - randomized self-checking bench for uart_rx_os16
module tb_uart_rx_os16;

  localparam int TICK_T = 40;
  localparam int BIT_T  = 16 * TICK_T;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  typedef struct {
    bit         err;
    logic [7:0] b;
  } exp_t;

  exp_t   expq[$];
  longint vcyc[$];

  uart_rx_os16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud      (baud),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  // baud toggles on clk falling edges, giving one tick every 4 clk
  always #20 baud = ~baud;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // line-level reference: a frame is start, 8 data bits LSB first, stop; result known up front
  task automatic send_frame(input logic [7:0] b, input logic stop);
    expq.push_back('{err: ~stop, b: b});
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_T);
    end
    rx = stop;
    #(BIT_T);
  endtask

  // cycle counter for pulse spacing
  always @(negedge clk) cyc++;

  // every output pulse must match the next expected frame outcome in order
  always @(negedge clk) begin
    if (rst_n && (data_valid || frame_err)) begin
      check("pulse_excl", {31'd0, data_valid & frame_err}, 32'd0);
      if (expq.size() == 0) begin
        check("spurious_pulse", {31'd0, data_valid | frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
        check("pulse_byte", {24'd0, data_out}, {24'd0, e.b});
      end
      if (data_valid) vcyc.push_back(cyc);
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    longint     gap;
    @(negedge clk);
    #100;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #200;

    // single good frame
    send_frame(8'h55, 1'b1);
    #(2 * BIT_T);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_hold", {24'd0, data_out}, 32'h55);
    check("t1_drained", expq.size(), 32'd0);

    // back-to-back frames, pulses ten bit-times apart
    vcyc.delete();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    #(2 * BIT_T);
    check("t2_count", vcyc.size(), 32'd2);
    if (vcyc.size() == 2) begin
      gap = vcyc[1] - vcyc[0];
      check("t2_gap", {31'd0, (gap >= 630 && gap <= 650)}, 32'd1);
    end

    // short low glitch: busy rises then falls, no pulses
    rx = 1'b0;
    #(3 * TICK_T);
    check("t3_busy_hi", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    #(16 * TICK_T);
    check("t3_busy_lo", {31'd0, busy}, 32'd0);

    // framing error followed by a held-low break, then a good frame
    send_frame(8'h3C, 1'b0);
    #(2 * BIT_T);
    check("t4_break_busy", {31'd0, busy}, 32'd1);
    check("t4_err_byte", {24'd0, data_out}, 32'h3C);
    rx = 1'b1;
    #(BIT_T);
    check("t4_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    #(2 * BIT_T);
    check("t4_data", {24'd0, data_out}, 32'h81);

    // reset in the middle of data bit 4 of 0xFF
    rx = 1'b0;
    #(BIT_T);
    rx = 1'b1;
    #(4 * BIT_T + BIT_T / 2);
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #10;
    check("t5_rst_data", {24'd0, data_out}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_valid", {31'd0, data_valid | frame_err}, 32'd0);
    #100;
    rst_n = 1'b1;
    #(BIT_T);
    send_frame(8'h12, 1'b1);
    #(2 * BIT_T);

    // line low across reset release: all-zero frame with bad stop, then break, then good frame
    rst_n = 1'b0;
    rx    = 1'b0;
    #100;
    expq.push_back('{err: 1'b1, b: 8'h00});
    rst_n = 1'b1;
    #(12 * BIT_T);
    rx = 1'b1;
    #(2 * BIT_T);
    send_frame(8'h7E, 1'b1);
    #(2 * BIT_T);
    check("t6_data", {24'd0, data_out}, 32'h7E);

    // random frames, occasional bad stop with break, random inter-frame gaps
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rb, rs);
      if (!rs) begin
        #($urandom_range(0, 2) * BIT_T);
        rx = 1'b1;
        #(BIT_T);
      end else begin
        #($urandom_range(0, 3) * TICK_T);
      end
    end
    #(2 * BIT_T);
    check("end_drained", expq.size(), 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
